// File: rtl/alu_ctrl_if.sv
// ID/EX ALU-control bus: decode-stage inputs and the registered selection returned to EX.
interface alu_ctrl_if #(
    parameter int unsigned SEL_W = 5
);
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             funct7_0;
    logic             stall_in;
    logic             flush;
    logic             out_valid;
    logic [SEL_W-1:0] alu_sel;
    logic             is_muldiv;
    logic             illegal;
    logic             busy;
    logic             stall_req;

    modport master (
        output in_valid, alu_op, funct3, funct7_5, funct7_0, stall_in, flush,
        input  out_valid, alu_sel, is_muldiv, illegal, busy, stall_req
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7_5, funct7_0, stall_in, flush,
        output out_valid, alu_sel, is_muldiv, illegal, busy, stall_req
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered RV32I/M ALU control at ID/EX; holds the output register for multi-cycle MUL/DIV.
module alu_ctrl_pipe #(
    parameter int unsigned SEL_W    = 5,
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned DIV_LAT  = 33
) (
    input logic       clk,
    input logic       rst_n,
    alu_ctrl_if.slave bus
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    localparam logic [4:0] C_AND  = 5'b00000;
    localparam logic [4:0] C_OR   = 5'b00001;
    localparam logic [4:0] C_ADD  = 5'b00010;
    localparam logic [4:0] C_XOR  = 5'b00011;
    localparam logic [4:0] C_SLL  = 5'b00100;
    localparam logic [4:0] C_SRL  = 5'b00101;
    localparam logic [4:0] C_SUB  = 5'b00110;
    localparam logic [4:0] C_SRA  = 5'b00111;
    localparam logic [4:0] C_SLT  = 5'b01000;
    localparam logic [4:0] C_SLTU = 5'b01001;
    localparam logic [4:0] C_MUL  = 5'b01010;

    logic [4:0]       base_c;
    logic             base_bad_c;
    logic [4:0]       code_c;
    logic             bad_c;
    logic             mul_c;
    logic             div_c;
    logic [SEL_W-1:0] sel_c;
    logic             hold_c;
    logic             capture_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next_c;

    // Base integer decode shared by R- and I-type; only ADD/SUB and SRL/SRA use bit 30.
    always_comb begin
        base_c     = C_ADD;
        base_bad_c = 1'b0;
        case (bus.funct3)
            3'b000: base_c = bus.funct7_5 ? C_SUB : C_ADD;
            3'b001: begin base_c = C_SLL;  base_bad_c = bus.funct7_5; end
            3'b010: begin base_c = C_SLT;  base_bad_c = bus.funct7_5; end
            3'b011: begin base_c = C_SLTU; base_bad_c = bus.funct7_5; end
            3'b100: begin base_c = C_XOR;  base_bad_c = bus.funct7_5; end
            3'b101: base_c = bus.funct7_5 ? C_SRA : C_SRL;
            3'b110: begin base_c = C_OR;   base_bad_c = bus.funct7_5; end
            default: begin base_c = C_AND; base_bad_c = bus.funct7_5; end
        endcase
    end

    // Top-level decode; M codes are contiguous from MUL, funct3[2] splits MUL from DIV/REM.
    always_comb begin
        code_c = C_ADD;
        bad_c  = 1'b0;
        mul_c  = 1'b0;
        div_c  = 1'b0;
        case (bus.alu_op)
            2'b00: code_c = C_ADD;
            2'b01: code_c = C_SUB;
            2'b10: begin
                if (bus.funct7_0) begin
                    if (ENABLE_M) begin
                        code_c = C_MUL + {2'b00, bus.funct3};
                        mul_c  = ~bus.funct3[2];
                        div_c  = bus.funct3[2];
                    end else begin
                        bad_c = 1'b1;
                    end
                end else begin
                    code_c = base_c;
                    bad_c  = base_bad_c;
                end
            end
            default: begin
                if (bus.funct3 != 3'b000) begin
                    code_c = base_c;
                    bad_c  = base_bad_c;
                end
            end
        endcase
        sel_c = bad_c ? {SEL_W{1'b1}} : SEL_W'(code_c);
    end

    assign hold_c    = bus.stall_in | bus.busy;
    assign capture_c = ~bus.flush & ~hold_c;

    // Occupancy counter runs down regardless of stall_in; loads only on capture.
    always_comb begin
        cnt_next_c = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        if (bus.flush) begin
            cnt_next_c = '0;
        end else if (capture_c && bus.in_valid) begin
            if (mul_c)      cnt_next_c = MUL_LOAD;
            else if (div_c) cnt_next_c = DIV_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.alu_sel   <= SEL_W'(C_ADD);
            bus.is_muldiv <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.stall_req <= 1'b0;
            cnt_q         <= '0;
        end else begin
            cnt_q         <= cnt_next_c;
            bus.busy      <= (cnt_next_c != '0);
            bus.stall_req <= (cnt_next_c != '0);
            if (bus.flush) begin
                bus.out_valid <= 1'b0;
                bus.alu_sel   <= SEL_W'(C_ADD);
                bus.is_muldiv <= 1'b0;
                bus.illegal   <= 1'b0;
            end else if (capture_c) begin
                bus.out_valid <= bus.in_valid;
                bus.alu_sel   <= bus.in_valid ? sel_c : SEL_W'(C_ADD);
                bus.is_muldiv <= bus.in_valid & (mul_c | div_c);
                bus.illegal   <= bus.in_valid & bad_c;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: default M-enabled instance plus an ENABLE_M=0 instance.
module tb_alu_ctrl_pipe;
    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned errors;

    alu_ctrl_if #(.SEL_W(5)) bus0 ();
    alu_ctrl_if #(.SEL_W(5)) bus1 ();

    alu_ctrl_pipe #(.SEL_W(5), .ENABLE_M(1'b1), .MUL_LAT(3), .DIV_LAT(33)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    alu_ctrl_pipe #(.SEL_W(5), .ENABLE_M(1'b0), .MUL_LAT(3), .DIV_LAT(33)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic f70);
        bus0.in_valid = v;
        bus0.alu_op   = op;
        bus0.funct3   = f3;
        bus0.funct7_5 = f75;
        bus0.funct7_0 = f70;
    endtask

    task automatic drv1(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic f70);
        bus1.in_valid = v;
        bus1.alu_op   = op;
        bus1.funct3   = f3;
        bus1.funct7_5 = f75;
        bus1.funct7_0 = f70;
    endtask

    logic [4:0] rexp [16] = '{5'h02, 5'h06, 5'h04, 5'h1F, 5'h08, 5'h1F, 5'h09, 5'h1F,
                              5'h03, 5'h1F, 5'h05, 5'h07, 5'h01, 5'h1F, 5'h00, 5'h1F};

    initial begin
        int n;
        int busy_n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drv0(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        drv1(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        bus0.stall_in = 1'b0;
        bus0.flush    = 1'b0;
        bus1.stall_in = 1'b0;
        bus1.flush    = 1'b0;
        tick();
        tick();
        check("rst_valid",   32'(bus0.out_valid), 32'd0);
        check("rst_sel",     32'(bus0.alu_sel),   32'h02);
        check("rst_muldiv",  32'(bus0.is_muldiv), 32'd0);
        check("rst_illegal", 32'(bus0.illegal),   32'd0);
        check("rst_busy",    32'(bus0.busy),      32'd0);
        check("rst_stall",   32'(bus0.stall_req), 32'd0);
        rst_n = 1'b1;

        // alu_op 00/01 ignore funct fields
        drv0(1'b1, 2'b00, 3'b111, 1'b1, 1'b1);
        tick();
        check("op00_sel",   32'(bus0.alu_sel),   32'h02);
        check("op00_valid", 32'(bus0.out_valid), 32'd1);
        check("op00_ill",   32'(bus0.illegal),   32'd0);
        drv0(1'b1, 2'b01, 3'b101, 1'b0, 1'b1);
        tick();
        check("op01_sel",    32'(bus0.alu_sel),   32'h06);
        check("op01_muldiv", 32'(bus0.is_muldiv), 32'd0);

        // R-type base sweep
        for (int i = 0; i < 16; i++) begin
            drv0(1'b1, 2'b10, 3'(i / 2), 1'(i % 2), 1'b0);
            tick();
            check($sformatf("rsel_%0d", i), 32'(bus0.alu_sel), 32'(rexp[i]));
            check($sformatf("rill_%0d", i), 32'(bus0.illegal), 32'(rexp[i] == 5'h1F));
        end

        // I-type
        drv0(1'b1, 2'b11, 3'b000, 1'b1, 1'b1);
        tick();
        check("i_addi_sel", 32'(bus0.alu_sel),   32'h02);
        check("i_addi_md",  32'(bus0.is_muldiv), 32'd0);
        check("i_addi_bsy", 32'(bus0.busy),      32'd0);
        drv0(1'b1, 2'b11, 3'b101, 1'b1, 1'b0);
        tick();
        check("i_srai_sel", 32'(bus0.alu_sel), 32'h07);
        drv0(1'b1, 2'b11, 3'b001, 1'b1, 1'b0);
        tick();
        check("i_slli_bad", 32'(bus0.alu_sel), 32'h1F);
        check("i_slli_ill", 32'(bus0.illegal), 32'd1);

        // in_valid low: illegal pattern must not leak
        drv0(1'b0, 2'b10, 3'b001, 1'b1, 1'b0);
        tick();
        check("inv_valid", 32'(bus0.out_valid), 32'd0);
        check("inv_sel",   32'(bus0.alu_sel),   32'h02);
        check("inv_ill",   32'(bus0.illegal),   32'd0);

        // DIV: busy 32 cycles, next op captured at edge 33
        drv0(1'b1, 2'b10, 3'b100, 1'b0, 1'b1);
        tick();
        check("div_sel",    32'(bus0.alu_sel),   32'h0E);
        check("div_md",     32'(bus0.is_muldiv), 32'd1);
        check("div_stall",  32'(bus0.stall_req), 32'd1);
        drv0(1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
        n = 0;
        while (bus0.busy && n < 50) begin
            n++;
            tick();
        end
        check("div_busy_cycles", 32'(n), 32'd32);
        check("div_held_sel",    32'(bus0.alu_sel), 32'h0E);
        tick();
        check("div_next_sel", 32'(bus0.alu_sel),   32'h02);
        check("div_next_md",  32'(bus0.is_muldiv), 32'd0);

        // MUL with stall_in high for 5 cycles
        drv0(1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
        tick();
        check("mul_sel", 32'(bus0.alu_sel), 32'h0A);
        busy_n = bus0.busy ? 1 : 0;
        bus0.stall_in = 1'b1;
        drv0(1'b1, 2'b01, 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus0.busy) busy_n++;
            check($sformatf("mul_hold_%0d", k), 32'(bus0.alu_sel), 32'h0A);
        end
        check("mul_busy_cycles", 32'(busy_n), 32'd2);
        bus0.stall_in = 1'b0;
        tick();
        check("mul_adv_sel", 32'(bus0.alu_sel),   32'h06);
        check("mul_adv_md",  32'(bus0.is_muldiv), 32'd0);

        // flush mid-DIV
        drv0(1'b1, 2'b10, 3'b101, 1'b0, 1'b1);
        tick();
        check("fl_div_sel", 32'(bus0.alu_sel), 32'h0F);
        drv0(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) tick();
        check("fl_busy_pre", 32'(bus0.busy), 32'd1);
        bus0.flush    = 1'b1;
        bus0.stall_in = 1'b1;
        tick();
        bus0.flush    = 1'b0;
        bus0.stall_in = 1'b0;
        check("fl_valid", 32'(bus0.out_valid), 32'd0);
        check("fl_busy",  32'(bus0.busy),      32'd0);
        check("fl_stall", 32'(bus0.stall_req), 32'd0);
        check("fl_sel",   32'(bus0.alu_sel),   32'h02);
        check("fl_md",    32'(bus0.is_muldiv), 32'd0);
        tick();
        check("fl_busy_after", 32'(bus0.busy), 32'd0);

        // reset mid-DIV
        drv0(1'b1, 2'b10, 3'b110, 1'b0, 1'b1);
        tick();
        check("rs_div_sel", 32'(bus0.alu_sel), 32'h10);
        drv0(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rs_valid", 32'(bus0.out_valid), 32'd0);
        check("rs_busy",  32'(bus0.busy),      32'd0);
        check("rs_stall", 32'(bus0.stall_req), 32'd0);
        check("rs_sel",   32'(bus0.alu_sel),   32'h02);
        tick();
        check("rs_busy_after", 32'(bus0.busy), 32'd0);

        // ENABLE_M=0 instance
        drv1(1'b1, 2'b10, 3'b100, 1'b0, 1'b1);
        tick();
        drv1(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        check("nm_sel",  32'(bus1.alu_sel),   32'h1F);
        check("nm_ill",  32'(bus1.illegal),   32'd1);
        check("nm_md",   32'(bus1.is_muldiv), 32'd0);
        check("nm_busy", 32'(bus1.busy),      32'd0);
        busy_n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus1.busy) busy_n++;
        end
        check("nm_busy_never", 32'(busy_n), 32'd0);
        drv1(1'b1, 2'b11, 3'b000, 1'b1, 1'b0);
        tick();
        check("nm_addi_sel", 32'(bus1.alu_sel), 32'h02);
        check("nm_addi_ill", 32'(bus1.illegal), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Parametrised, registered ALU control stage for the RV32 pipeline, placed at the ID/EX boundary.
- Decodes ALUOp, funct3, funct7[5] and funct7[0] into a widened ALU selection that covers the full RV32I ALU set plus optional RV32M.
- Sequences multi-cycle MUL/DIV by holding its output register and raising a stall request for a fixed, parameterised latency.
- Supports pipeline hold and flush.

Parameters:
- SEL_W, 5, width of alu_sel; must be >= 5.
- ENABLE_M, 1, 1 = decode RV32M; 0 = M-encodings flagged illegal.
- MUL_LAT, 3, cycles a MUL-class op occupies the output register (>= 1).
- DIV_LAT, 33, cycles a DIV/REM-class op occupies the output register (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  decode-stage instruction valid.
- alu_op  in  2  00 add, 01 sub (branch), 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction bits [14:12].
- funct7_5  in  1  instruction bit 30.
- funct7_0  in  1  instruction bit 25 (M-extension marker).
- stall_in  in  1  downstream hold.
- flush  in  1  kill the registered instruction.
- out_valid  out  1  registered valid.
- alu_sel  out  SEL_W  registered ALU selection.
- is_muldiv  out  1  registered op is MUL/DIV/REM.
- illegal  out  1  registered op has an undecodable encoding.
- busy  out  1  multi-cycle op in progress (counter != 0).
- stall_req  out  1  equals busy; upstream must hold its inputs.

Behaviour:
- Codes (5-bit, zero-extended to SEL_W):
  - ADD 00010, SUB 00110, AND 00000, OR 00001, XOR 00011.
  - SLL 00100, SRL 00101, SRA 00111, SLT 01000, SLTU 01001.
  - MUL 01010, MULH 01011, MULHSU 01100, MULHU 01101.
  - DIV 01110, DIVU 01111, REM 10000, REMU 10001.
  - INVALID = all ones.
- alu_op 00 -> ADD; alu_op 01 -> SUB. funct fields are ignored for both.
- alu_op 10 (R-type):
  - funct7_0=1 and ENABLE_M=1 -> M op indexed by funct3 (000 MUL ... 111 REMU).
  - funct7_0=1 and ENABLE_M=0 -> INVALID.
  - Otherwise, by funct3: 000 ADD/SUB (funct7_5 0/1); 001 SLL (f7_5 must be 0); 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA (f7_5 0/1); 110 OR; 111 AND.
  - f7_5=1 with funct3 not in {000, 101} -> INVALID.
- alu_op 11 (I-type): same as R-type, except funct3 000 is always ADD and funct7_0 is ignored. The M path is never taken.
- INVALID sets illegal=1. illegal is only meaningful when out_valid=1.
- Latency: one cycle, from inputs at edge N to outputs valid after edge N.
- Update priority at each edge: reset > flush > hold > capture.
  - hold = stall_in | busy.
  - Capture loads out_valid <= in_valid, plus alu_sel, is_muldiv and illegal.
  - When in_valid=0: alu_sel <= ADD, is_muldiv <= 0, illegal <= 0.
- Counter (width clog2(max(MUL_LAT, DIV_LAT))+1):
  - On capture of a valid MUL-class op, load MUL_LAT-1; on a valid DIV/REM-class op, load DIV_LAT-1. Otherwise load 0.
  - Decrements by 1 every edge while nonzero, independent of stall_in.
  - A muldiv op therefore occupies the output register for exactly LAT cycles when stall_in=0.
  - LAT=1 gives no busy assertion.
- flush: out_valid <= 0, alu_sel <= ADD, is_muldiv <= 0, illegal <= 0, counter <= 0. busy drops the following cycle. A flush during a DIV aborts it.
- Reset (rst_n=0 at edge): out_valid 0, alu_sel ADD, is_muldiv 0, illegal 0, counter 0, busy 0, stall_req 0. Reset mid-DIV aborts with no residual stall.
- Simultaneous flush and stall_in: flush wins.
- stall_in while busy: the counter still counts. The output holds until both are low.
- in_valid while busy: input is not captured. Upstream must keep it stable, as required by stall_req.

Test Plan:
- Reset, then alu_op=00 and 01 with in_valid=1 -> next cycle alu_sel 00010, then 00110. out_valid=1, illegal=0.
- alu_op=10 sweep over all funct3 x f7_5 with f7_0=0 -> codes exactly as tabled. funct3=001, f7_5=1 -> alu_sel=11111, illegal=1.
- alu_op=10, funct3=100, f7_0=1, DIV_LAT=33 -> alu_sel=01110, is_muldiv=1, busy high for exactly 32 cycles. The next instruction is captured at edge 33 after the DIV capture.
- MUL (funct3=000, f7_0=1), MUL_LAT=3, with stall_in held high 5 cycles -> busy for 2 cycles. The output holds 5 cycles, then advances when stall_in drops.
- DIV in flight with flush asserted at cycle 10 -> next cycle out_valid=0, busy=0, alu_sel=00010. A repeat of the scenario with rst_n=0 at cycle 10 gives the same result.
- ENABLE_M=0, alu_op=10, f7_0=1 -> alu_sel=11111, illegal=1, busy never asserted. alu_op=11, funct3=000, f7_5=1 -> ADD 00010.
